// File: rtl/ysyx_220066_clint.sv
// Core-local interruptor: msip / mtimecmp / mtime behind a one-outstanding request/response bus.
// Optional mtime prescaler is enabled by defining YSYX_220066_CLINT_PRESCALE_EN.
module ysyx_220066_clint #(
  parameter int unsigned PRESCALE = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_wen,
  input  logic [63:0] req_addr,
  input  logic [63:0] req_wdata,
  input  logic [7:0]  req_wstrb,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [63:0] resp_rdata,
  output logic        resp_err,
  output logic        timer_irq,
  output logic        soft_irq
);

  localparam logic [63:0] ADDR_MSIP     = 64'h0000_0000_0200_0000;
  localparam logic [63:0] ADDR_MTIMECMP = 64'h0000_0000_0200_4000;
  localparam logic [63:0] ADDR_MTIME    = 64'h0000_0000_0200_BFF8;

  typedef enum logic [0:0] {S_IDLE = 1'b0, S_RESP = 1'b1} state_e;

  if (PRESCALE < 2 || PRESCALE > 65535) begin : g_bad_prescale
    $error("PRESCALE must lie in 2..65535");
  end

  function automatic logic [63:0] merge_bytes(input logic [63:0] old_v,
                                              input logic [63:0] new_v,
                                              input logic [7:0]  strb);
    logic [63:0] res;
    res = old_v;
    for (int b = 0; b < 8; b++) begin
      if (strb[b]) res[8*b +: 8] = new_v[8*b +: 8];
    end
    return res;
  endfunction

  state_e      state_q, state_d;
  logic        msip_q, msip_d;
  logic [63:0] mtimecmp_q, mtimecmp_d;
  logic [63:0] mtime_q, mtime_d;
  logic [63:0] rdata_q, rdata_d;
  logic        err_q, err_d;
  logic        accept_s, wr_s, mapped_s, tick_s;
  logic        sel_msip_s, sel_cmp_s, sel_mtime_s;

  // A write with no byte enabled is not treated as a write at all
  always_comb begin
    sel_msip_s  = (req_addr == ADDR_MSIP);
    sel_cmp_s   = (req_addr == ADDR_MTIMECMP);
    sel_mtime_s = (req_addr == ADDR_MTIME);
    mapped_s    = sel_msip_s | sel_cmp_s | sel_mtime_s;
    accept_s    = (state_q == S_IDLE) && req_valid;
    wr_s        = accept_s && req_wen && (req_wstrb != 8'h00) && mapped_s;
  end

`ifdef YSYX_220066_CLINT_PRESCALE_EN
  localparam logic [15:0] DIV_LAST = 16'(PRESCALE - 1);
  logic [15:0] div_q, div_d;

  always_comb begin
    tick_s = (div_q == DIV_LAST);
    if (wr_s && sel_mtime_s) begin
      div_d = 16'd0;
    end else if (tick_s) begin
      div_d = 16'd0;
    end else begin
      div_d = div_q + 16'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) div_q <= 16'd0;
    else     div_q <= div_d;
  end
`else
  always_comb begin
    tick_s = 1'b1;
  end
`endif

  // FSM next state: no new request is taken on the response handshake edge
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (req_valid) state_d = S_RESP; else state_d = S_IDLE;
      S_RESP:  if (resp_ready) state_d = S_IDLE; else state_d = S_RESP;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    msip_d     = msip_q;
    mtimecmp_d = mtimecmp_q;
    if (wr_s && sel_msip_s && req_wstrb[0]) msip_d = req_wdata[0];
    if (wr_s && sel_cmp_s) mtimecmp_d = merge_bytes(mtimecmp_q, req_wdata, req_wstrb);
    if (wr_s && sel_mtime_s) begin
      mtime_d = merge_bytes(mtime_q, req_wdata, req_wstrb);
    end else if (tick_s) begin
      mtime_d = mtime_q + 64'd1;
    end else begin
      mtime_d = mtime_q;
    end
  end

  // Response capture: reads see register values from before this edge's update
  always_comb begin
    rdata_d = rdata_q;
    err_d   = err_q;
    if (accept_s) begin
      err_d   = ~mapped_s;
      rdata_d = 64'd0;
      if (!req_wen && sel_msip_s)  rdata_d = {63'd0, msip_q};
      if (!req_wen && sel_cmp_s)   rdata_d = mtimecmp_q;
      if (!req_wen && sel_mtime_s) rdata_d = mtime_q;
    end else if (state_q == S_RESP && resp_ready) begin
      rdata_d = 64'd0;
      err_d   = 1'b0;
    end else begin
      rdata_d = rdata_q;
      err_d   = err_q;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      msip_q     <= 1'b0;
      mtimecmp_q <= 64'hFFFF_FFFF_FFFF_FFFF;
      mtime_q    <= 64'd0;
      rdata_q    <= 64'd0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      msip_q     <= msip_d;
      mtimecmp_q <= mtimecmp_d;
      mtime_q    <= mtime_d;
      rdata_q    <= rdata_d;
      err_q      <= err_d;
    end
  end

  always_comb begin
    req_ready  = (state_q == S_IDLE);
    resp_valid = (state_q == S_RESP);
    resp_rdata = rdata_q;
    resp_err   = err_q;
    timer_irq  = (mtime_q >= mtimecmp_q);
    soft_irq   = msip_q;
  end

endmodule
